// File: rtl/sound_frame_seq.sv
// rtl/sound_frame_seq.sv - APU frame sequencer and NRx1/NRx4/NR52 decode driving channel length inputs
module sound_frame_seq #(
    parameter int START_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       div_bit,
    input  logic       wr,
    input  logic [7:0] addr,
    input  logic [7:0] din,
    output logic       apu_on,
    output logic [2:0] step,
    output logic       len_tick,
    output logic       sweep_tick,
    output logic       env_tick,
    output logic       start_ch1,
    output logic       start_ch2,
    output logic       start_ch3,
    output logic       start_ch4,
    output logic       single_ch1,
    output logic       single_ch2,
    output logic       single_ch3,
    output logic       single_ch4,
    output logic [5:0] length_ch1,
    output logic [5:0] length_ch2,
    output logic [7:0] length_ch3,
    output logic [5:0] length_ch4
);

    localparam logic [7:0] ADDR_NR11 = 8'h11;
    localparam logic [7:0] ADDR_NR14 = 8'h14;
    localparam logic [7:0] ADDR_NR21 = 8'h16;
    localparam logic [7:0] ADDR_NR24 = 8'h19;
    localparam logic [7:0] ADDR_NR31 = 8'h1B;
    localparam logic [7:0] ADDR_NR34 = 8'h1E;
    localparam logic [7:0] ADDR_NR41 = 8'h20;
    localparam logic [7:0] ADDR_NR44 = 8'h23;
    localparam logic [7:0] ADDR_NR52 = 8'h26;
    localparam logic [3:0] START_INIT = 4'(START_W);

    logic       div_d;
    logic       div_fall;
    logic       nr52_wr;
    logic       power_off;
    logic       power_on;
    logic       reg_wr;
    logic [3:0] trig;
    logic [3:0] start_cnt [4];

    always_comb begin
        div_fall  = div_d & ~div_bit;
        nr52_wr   = wr && (addr == ADDR_NR52);
        power_off = nr52_wr && apu_on && !din[7];
        power_on  = nr52_wr && !apu_on && din[7];
        reg_wr    = wr && apu_on && (addr != ADDR_NR52);
        trig[0]   = reg_wr && din[7] && (addr == ADDR_NR14);
        trig[1]   = reg_wr && din[7] && (addr == ADDR_NR24);
        trig[2]   = reg_wr && din[7] && (addr == ADDR_NR34);
        trig[3]   = reg_wr && din[7] && (addr == ADDR_NR44);
    end

    // Power transitions take priority over a coincident DIV edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_d      <= 1'b0;
            apu_on     <= 1'b0;
            step       <= 3'd0;
            len_tick   <= 1'b0;
            sweep_tick <= 1'b0;
            env_tick   <= 1'b0;
        end else begin
            div_d      <= div_bit;
            len_tick   <= 1'b0;
            sweep_tick <= 1'b0;
            env_tick   <= 1'b0;
            if (nr52_wr) begin
                apu_on <= din[7];
            end
            if (power_off || power_on) begin
                step <= 3'd0;
            end else if (apu_on && div_fall) begin
                step       <= step + 3'd1;
                len_tick   <= ~step[0];
                sweep_tick <= (step[1:0] == 2'b10);
                env_tick   <= (step == 3'd7);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            single_ch1 <= 1'b0;
            single_ch2 <= 1'b0;
            single_ch3 <= 1'b0;
            single_ch4 <= 1'b0;
            length_ch1 <= 6'd0;
            length_ch2 <= 6'd0;
            length_ch3 <= 8'd0;
            length_ch4 <= 6'd0;
        end else if (power_off) begin
            single_ch1 <= 1'b0;
            single_ch2 <= 1'b0;
            single_ch3 <= 1'b0;
            single_ch4 <= 1'b0;
            length_ch1 <= 6'd0;
            length_ch2 <= 6'd0;
            length_ch3 <= 8'd0;
            length_ch4 <= 6'd0;
        end else if (reg_wr) begin
            case (addr)
                ADDR_NR11: length_ch1 <= din[5:0];
                ADDR_NR21: length_ch2 <= din[5:0];
                ADDR_NR31: length_ch3 <= din;
                ADDR_NR41: length_ch4 <= din[5:0];
                ADDR_NR14: single_ch1 <= din[6];
                ADDR_NR24: single_ch2 <= din[6];
                ADDR_NR34: single_ch3 <= din[6];
                ADDR_NR44: single_ch4 <= din[6];
                default: ;
            endcase
        end
    end

    // A retrigger reloads the counter so an active pulse extends without a gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) start_cnt[i] <= 4'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (power_off) begin
                    start_cnt[i] <= 4'd0;
                end else if (trig[i]) begin
                    start_cnt[i] <= START_INIT;
                end else if (start_cnt[i] != 4'd0) begin
                    start_cnt[i] <= start_cnt[i] - 4'd1;
                end
            end
        end
    end

    assign start_ch1 = (start_cnt[0] != 4'd0);
    assign start_ch2 = (start_cnt[1] != 4'd0);
    assign start_ch3 = (start_cnt[2] != 4'd0);
    assign start_ch4 = (start_cnt[3] != 4'd0);

endmodule

// File: tb/tb_sound_frame_seq.sv
// tb/tb_sound_frame_seq.sv - randomized and directed bench for sound_frame_seq against a behavioural model
module tb_sound_frame_seq;

    localparam int START_W = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       div_bit = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] din = 8'h00;
    logic       apu_on;
    logic [2:0] step;
    logic       len_tick, sweep_tick, env_tick;
    logic       start_ch1, start_ch2, start_ch3, start_ch4;
    logic       single_ch1, single_ch2, single_ch3, single_ch4;
    logic [5:0] length_ch1, length_ch2, length_ch4;
    logic [7:0] length_ch3;

    sound_frame_seq #(.START_W(START_W)) dut (
        .clk(clk), .rst(rst), .div_bit(div_bit), .wr(wr), .addr(addr), .din(din),
        .apu_on(apu_on), .step(step),
        .len_tick(len_tick), .sweep_tick(sweep_tick), .env_tick(env_tick),
        .start_ch1(start_ch1), .start_ch2(start_ch2), .start_ch3(start_ch3), .start_ch4(start_ch4),
        .single_ch1(single_ch1), .single_ch2(single_ch2), .single_ch3(single_ch3), .single_ch4(single_ch4),
        .length_ch1(length_ch1), .length_ch2(length_ch2), .length_ch3(length_ch3), .length_ch4(length_ch4)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: clock index n, and each start pulse is "high until cycle start_end".
    int         n = 0;
    bit         m_on, m_div_d;
    int         m_step;
    bit         m_len_t, m_swp_t, m_env_t;
    int         m_len [4];
    bit         m_single [4];
    int         start_end [4];

    function automatic int len_ch(input logic [7:0] a);
        case (a)
            8'h11: return 0;
            8'h16: return 1;
            8'h1B: return 2;
            8'h20: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int ctl_ch(input logic [7:0] a);
        case (a)
            8'h14: return 0;
            8'h19: return 1;
            8'h1E: return 2;
            8'h23: return 3;
            default: return -1;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_on = 0; m_div_d = 0; m_step = 0;
            m_len_t = 0; m_swp_t = 0; m_env_t = 0;
            for (int i = 0; i < 4; i++) begin
                m_len[i] = 0; m_single[i] = 0; start_end[i] = 0;
            end
        end else begin
            bit fall;
            bit new_on;
            int c;
            n++;
            fall = m_div_d && !div_bit;
            m_div_d = div_bit;
            m_len_t = 0; m_swp_t = 0; m_env_t = 0;
            if (wr && addr == 8'h26) begin
                new_on = din[7];
                if (m_on && !new_on) begin
                    m_step = 0;
                    for (int i = 0; i < 4; i++) begin
                        m_len[i] = 0; m_single[i] = 0; start_end[i] = 0;
                    end
                end else if (!m_on && new_on) begin
                    m_step = 0;
                end else if (m_on && fall) begin
                    m_len_t = (m_step % 2 == 0);
                    m_swp_t = (m_step % 4 == 2);
                    m_env_t = (m_step == 7);
                    m_step  = (m_step + 1) % 8;
                end
                m_on = new_on;
            end else begin
                if (m_on && fall) begin
                    m_len_t = (m_step % 2 == 0);
                    m_swp_t = (m_step % 4 == 2);
                    m_env_t = (m_step == 7);
                    m_step  = (m_step + 1) % 8;
                end
                if (wr && m_on) begin
                    c = len_ch(addr);
                    if (c >= 0) m_len[c] = (c == 2) ? int'(din) : int'(din & 8'h3F);
                    c = ctl_ch(addr);
                    if (c >= 0) begin
                        m_single[c] = din[6];
                        if (din[7]) start_end[c] = n + START_W;
                    end
                end
            end
        end
    end

    bit check_en = 0;

    always @(negedge clk) begin
        if (check_en) begin
            check("apu_on", 64'(apu_on), 64'(m_on));
            check("step", 64'(step), 64'(m_step));
            check("ticks", 64'({len_tick, sweep_tick, env_tick}), 64'({m_len_t, m_swp_t, m_env_t}));
            check("start", 64'({start_ch1, start_ch2, start_ch3, start_ch4}),
                  64'({n < start_end[0], n < start_end[1], n < start_end[2], n < start_end[3]}));
            check("single", 64'({single_ch1, single_ch2, single_ch3, single_ch4}),
                  64'({m_single[0], m_single[1], m_single[2], m_single[3]}));
            check("lengths", 64'({length_ch1, length_ch2, length_ch3, length_ch4}),
                  64'({m_len[0][5:0], m_len[1][5:0], m_len[2][7:0], m_len[3][5:0]}));
        end
    end

    bit count_en = 0;
    int n_len = 0, n_swp = 0, n_env = 0;
    always @(negedge clk) begin
        if (count_en) begin
            n_len += int'(len_tick);
            n_swp += int'(sweep_tick);
            n_env += int'(env_tick);
        end
    end

    function automatic logic [63:0] all_outputs();
        return 64'({apu_on, step, len_tick, sweep_tick, env_tick,
                    start_ch1, start_ch2, start_ch3, start_ch4,
                    single_ch1, single_ch2, single_ch3, single_ch4,
                    length_ch1, length_ch2, length_ch3, length_ch4});
    endfunction

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
        addr = a; din = d; wr = 1'b1;
        @(posedge clk);
        #2;
        wr = 1'b0;
    endtask

    task automatic div_edge();
        div_bit = 1'b1;
        idle(2);
        div_bit = 1'b0;
        idle(2);
    endtask

    initial begin
        logic [7:0] addr_pool [13];
        addr_pool = '{8'h11, 8'h14, 8'h16, 8'h19, 8'h1B, 8'h1E, 8'h20, 8'h23,
                      8'h26, 8'h12, 8'h25, 8'h27, 8'h00};

        idle(3);
        check("reset_all_zero", all_outputs(), 64'd0);
        rst = 1'b1;
        check_en = 1;
        idle(2);

        // Power-on and eight DIV falling edges
        reg_write(8'h26, 8'h80);
        count_en = 1;
        repeat (8) div_edge();
        idle(1);
        count_en = 0;
        check("seq_step_wrap", 64'(step), 64'd0);
        check("seq_len_count", 64'(n_len), 64'd4);
        check("seq_sweep_count", 64'(n_swp), 64'd2);
        check("seq_env_count", 64'(n_env), 64'd1);

        // CH1 trigger, then a non-trigger NR14 write
        reg_write(8'h11, 8'h3F);
        reg_write(8'h14, 8'hC0);
        check("ch1_start_first", 64'(start_ch1), 64'd1);
        check("ch1_length", 64'(length_ch1), 64'h3F);
        idle(1);
        check("ch1_start_second", 64'(start_ch1), 64'd1);
        idle(1);
        check("ch1_start_ended", 64'(start_ch1), 64'd0);
        reg_write(8'h14, 8'h40);
        check("ch1_no_start", 64'(start_ch1), 64'd0);

        // CH3 length and a back-to-back retrigger
        reg_write(8'h1B, 8'hA5);
        reg_write(8'h1E, 8'h80);
        idle(4);
        reg_write(8'h1E, 8'h80);
        reg_write(8'h1E, 8'h80);
        idle(1);
        check("ch3_retrig_third", 64'(start_ch3), 64'd1);
        idle(1);
        check("ch3_retrig_ended", 64'(start_ch3), 64'd0);
        check("ch3_length", 64'(length_ch3), 64'hA5);

        // Ignored addresses
        reg_write(8'h12, 8'hFF);
        reg_write(8'h25, 8'hFF);
        reg_write(8'h27, 8'hFF);

        // Power-off coincident with a DIV edge at step 5
        reg_write(8'h19, 8'h40);
        reg_write(8'h16, 8'h10);
        repeat (5) div_edge();
        check("pre_off_step", 64'(step), 64'd5);
        div_bit = 1'b1;
        idle(2);
        div_bit = 1'b0;
        reg_write(8'h26, 8'h00);
        check("off_step", 64'(step), 64'd0);
        check("off_ticks", 64'({len_tick, sweep_tick, env_tick}), 64'd0);
        check("off_single_len", 64'({single_ch2, length_ch2}), 64'd0);
        reg_write(8'h19, 8'h80);
        check("off_no_start", 64'(start_ch2), 64'd0);
        idle(1);
        div_edge();
        check("off_no_step", 64'(step), 64'd0);

        // Asynchronous reset in the middle of a start pulse, at step 3
        reg_write(8'h26, 8'h80);
        repeat (3) div_edge();
        reg_write(8'h14, 8'h80);
        rst = 1'b0;
        #1;
        check("async_rst_zero", all_outputs(), 64'd0);
        idle(1);
        rst = 1'b1;
        div_edge();
        check("post_rst_off", 64'({apu_on, step}), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(3) == 0) div_bit = ~div_bit;
            wr = ($urandom_range(2) == 0);
            addr = addr_pool[$urandom_range(12)];
            if (addr == 8'h00) addr = 8'($urandom);
            din = 8'($urandom);
            if (addr == 8'h26 && $urandom_range(7) != 0) din[7] = 1'b1;
            if (i % 997 == 500) begin
                rst = 1'b0;
                #1;
                check("rand_async_rst", all_outputs(), 64'd0);
                @(posedge clk);
                #2;
                rst = 1'b1;
            end else begin
                @(posedge clk);
                #2;
            end
        end
        wr = 1'b0;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
